// File: rtl/priority_decoder_if.sv
// rtl/priority_decoder_if.sv - encoder-side and sink-side handshake bundle for the priority decoder
interface priority_decoder_if;
    // Encoder side: encoded index, valid flag and strobe, with back-pressure
    logic y0;
    logic y1;
    logic y2;
    logic valid;
    logic in_strobe;
    logic in_ready;

    // Sink side: one-hot decode of the head entry with its handshake
    logic o0;
    logic o1;
    logic o2;
    logic o3;
    logic o4;
    logic o5;
    logic o6;
    logic o7;
    logic out_valid;
    logic out_ready;

    // Source of codes and consumer of the decode (testbench / surrounding logic)
    modport master (
        output y0, y1, y2, valid, in_strobe, out_ready,
        input  in_ready, o0, o1, o2, o3, o4, o5, o6, o7, out_valid
    );

    // The decoder itself
    modport slave (
        input  y0, y1, y2, valid, in_strobe, out_ready,
        output in_ready, o0, o1, o2, o3, o4, o5, o6, o7, out_valid
    );
endinterface

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - buffered 3-to-8 decoder of priority-encoder codes with sticky seen mask and idle counter
module priority_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    priority_decoder_if.slave          bus,
    input  logic                       clr,
    output logic [7:0]                 seen,
    output logic [7:0]                 idle_cnt,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Entry storage and pointers; full/empty come only from level_q
    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Registered decode of the head entry
    logic [7:0]    o_q, o_d;
    logic          out_valid_q, out_valid_d;

    // Statistics
    logic [7:0]    seen_q, seen_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;

    // Handshake terms
    logic          in_ready;
    logic          push;
    logic          pop;
    logic          idle_strobe;
    logic [2:0]    in_idx;
    logic [LW-1:0] level_after_pop;
    logic [2:0]    head_idx;

    // in_ready depends only on registered level so it never combines with out_ready
    assign in_ready    = (level_q < DEPTH_L);
    assign in_idx      = {bus.y2, bus.y1, bus.y0};
    assign push        = bus.in_strobe & bus.valid & in_ready;
    assign pop         = out_valid_q & bus.out_ready;
    assign idle_strobe = bus.in_strobe & ~bus.valid;

    // Storage write and pointer/level bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_idx;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase
    end

    // Next head: a push into an otherwise-empty buffer bypasses storage so the
    // decode appears one edge after the push, even when the old head pops now
    always_comb begin
        level_after_pop = pop ? (level_q - ONE_L) : level_q;
        if (push && (level_after_pop == '0)) begin
            head_idx = in_idx;
        end else begin
            head_idx = mem_q[rd_ptr_d];
        end
        out_valid_d = (level_d != '0);
        o_d         = '0;
        for (int k = 0; k < 8; k++) begin
            o_d[k] = out_valid_d && (head_idx == 3'(k));
        end
    end

    // Sticky seen mask and saturating idle counter; clr clears first, then
    // the current pop / idle strobe is applied on top
    always_comb begin
        seen_d     = clr ? 8'h00 : seen_q;
        idle_cnt_d = clr ? 8'h00 : idle_cnt_q;
        if (pop) begin
            seen_d = seen_d | o_q;
        end
        if (idle_strobe && (idle_cnt_d != 8'hFF)) begin
            idle_cnt_d = idle_cnt_d + 8'd1;
        end
    end

    // State registers; reset discards all buffered entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            o_q         <= 8'h00;
            out_valid_q <= 1'b0;
            seen_q      <= 8'h00;
            idle_cnt_q  <= 8'h00;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
            seen_q      <= seen_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.o0        = o_q[0];
    assign bus.o1        = o_q[1];
    assign bus.o2        = o_q[2];
    assign bus.o3        = o_q[3];
    assign bus.o4        = o_q[4];
    assign bus.o5        = o_q[5];
    assign bus.o6        = o_q[6];
    assign bus.o7        = o_q[7];

    assign seen     = seen_q;
    assign idle_cnt = idle_cnt_q;
    assign level    = level_q;
endmodule

// File: tb/tb_priority_decoder.sv
// tb/tb_priority_decoder.sv - self-checking bench for priority_decoder against a queue-based reference
module tb_priority_decoder;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] seen;
    logic [7:0] idle_cnt;
    logic [2:0] level;

    priority_decoder_if bus ();

    priority_decoder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr      (clr),
        .seen     (seen),
        .idle_cnt (idle_cnt),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [7:0] ovec = {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};

    int         vectors;
    int         miscompares;
    int         mq[$];
    logic [7:0] m_seen;
    int         m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] eo;
        eo = (mq.size() != 0) ? (8'd1 << mq[0]) : 8'd0;
        chk({tag, "_level"},     32'(level),         32'(mq.size()));
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        chk({tag, "_o"},         32'(ovec),          32'(eo));
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(mq.size() < DEPTH));
        chk({tag, "_seen"},      32'(seen),          32'(m_seen));
        chk({tag, "_idle_cnt"},  32'(idle_cnt),      32'(m_idle));
    endtask

    task automatic model_reset();
        mq.delete();
        m_seen = 8'h00;
        m_idle = 0;
    endtask

    // Drive one cycle of stimulus, advance the reference across the edge, then compare
    task automatic cycle(input string tag, input bit s, input bit v, input logic [2:0] idx,
                         input bit ordy, input bit c);
        bit pop;
        bit push;
        int head;
        bus.in_strobe = s;
        bus.valid     = v;
        {bus.y2, bus.y1, bus.y0} = idx;
        bus.out_ready = ordy;
        clr           = c;
        pop  = (mq.size() != 0) && ordy;
        push = s && v && (mq.size() < DEPTH);
        @(posedge clk);
        #1;
        if (c) begin
            m_seen = 8'h00;
            m_idle = 0;
        end
        if (pop) begin
            head = mq.pop_front();
            m_seen[head] = 1'b1;
        end
        if (push) mq.push_back(int'(idx));
        if (s && !v && m_idle != 255) m_idle++;
        check_all(tag);
    endtask

    function automatic logic [2:0] encode(input logic [7:0] p);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 0; b < 8; b++) if (p[b]) r = 3'(b);
        return r;
    endfunction

    initial begin
        logic [7:0] pat;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.in_strobe = 1'b0;
        bus.valid     = 1'b0;
        bus.y0 = 1'b0; bus.y1 = 1'b0; bus.y2 = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single code 5 with out_ready high; first push right after release
        cycle("single_push", 1, 1, 3'd5, 1, 0);
        chk("single_o5", 32'(ovec), 32'h20);
        cycle("single_pop", 0, 0, 3'd0, 1, 0);
        chk("single_seen", 32'(seen), 32'h20);
        chk("single_level", 32'(level), 32'd0);

        // Fill and back-pressure: fifth push dropped
        cycle("fill_clr", 0, 0, 3'd0, 0, 1);
        for (int i = 0; i < 5; i++) cycle("fill_push", 1, 1, 3'(i), 0, 0);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd4);
        cycle("drain_first", 0, 0, 3'd0, 1, 0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 3'd0, 1, 0);

        // Full with simultaneous pop and push offer: push refused
        for (int i = 0; i < 4; i++) cycle("full_fill", 1, 1, 3'(7 - i), 0, 0);
        cycle("full_poppush", 1, 1, 3'd2, 1, 0);
        chk("full_poppush_level", 32'(level), 32'd3);
        for (int i = 0; i < 4; i++) cycle("full_drain", 0, 0, 3'd0, 1, 0);

        // Idle strobes saturate, then clear
        cycle("idle_clr", 0, 0, 3'd0, 1, 1);
        for (int i = 0; i < 300; i++) cycle("idle", 1, 0, 3'($urandom_range(0, 7)), 1, 0);
        chk("idle_sat", 32'(idle_cnt), 32'd255);
        cycle("idle_clr2", 0, 0, 3'd0, 1, 1);
        chk("idle_cleared", 32'(idle_cnt), 32'd0);
        cycle("idle_clr_strobe", 1, 0, 3'd0, 1, 1);
        chk("idle_clr_strobe_one", 32'(idle_cnt), 32'd1);

        // Concurrency at level 2: push 6, pop and clr together
        cycle("conc_push1", 1, 1, 3'd1, 0, 0);
        cycle("conc_push2", 1, 1, 3'd2, 0, 0);
        cycle("conc_all", 1, 1, 3'd6, 1, 1);
        chk("conc_level", 32'(level), 32'd2);
        chk("conc_seen", 32'(seen), 32'h02);
        cycle("conc_drain1", 0, 0, 3'd0, 1, 0);
        chk("conc_tail6", 32'(ovec), 32'h40);
        cycle("conc_drain2", 0, 0, 3'd0, 1, 0);

        // Full sweep of 8-bit encoder inputs through a priority-encoder model
        cycle("sweep_clr", 0, 0, 3'd0, 1, 1);
        for (int p = 0; p < 256; p++) begin
            pat = 8'(p);
            cycle("sweep", 1, pat != 8'h00, encode(pat), 1, 0);
        end
        cycle("sweep_drain", 0, 0, 3'd0, 1, 0);
        chk("sweep_seen", 32'(seen), 32'hFF);
        chk("sweep_idle", 32'(idle_cnt), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 31) == 0));
        end

        // Reset mid-operation at level 3
        for (int i = 0; i < 4; i++) cycle("rst_drain", 0, 0, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) cycle("rst_fill", 1, 1, 3'(i + 3), 0, 0);
        chk("rst_pre_level", 32'(level), 32'd3);
        bus.in_strobe = 1'b0;
        bus.valid     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk); @(posedge clk); #1;
        check_all("rst_held");
        rst_n = 1'b1;
        cycle("rst_after1", 0, 0, 3'd0, 1, 0);
        cycle("rst_after2", 0, 0, 3'd0, 1, 0);
        cycle("rst_first_push", 1, 1, 3'd3, 0, 0);
        chk("rst_first_o3", 32'(ovec), 32'h08);
        cycle("rst_final_pop", 0, 0, 3'd0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
